piso_tx_ctrl: RTL and testbench

Sequencing controller for the team's parallel-in/serial-out shift datapath: accepts a WIDTH-bit word over a valid/ready handshake and loads it into an internal shift register. It then shifts the word out one bit per clock with a frame-enable strobe and signals completion. A programmable inter-frame gap follows each frame. It sits between a parallel producer (FSM or FIFO) and a serial line, and replaces hand-driven `shift_load` sequencing.

---
 rtl/piso_tx_ctrl_if.sv | 12 +
 rtl/piso_tx_ctrl.sv | 119 +++++++++++
 tb/tb_piso_tx_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_tx_ctrl_if.sv
// Producer-side handshake bundle for piso_tx_ctrl: parallel word, valid/ready and frame abort.
interface piso_tx_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic             abort;

    modport master (output tx_valid, output tx_data, output abort, input tx_ready);
    modport slave  (input tx_valid, input tx_data, input abort, output tx_ready);
endinterface

// File: rtl/piso_tx_ctrl.sv
// Parallel-in/serial-out sequencing controller: accepts a word, shifts it out one bit per
// clock with an enable strobe, pulses done, then holds off for a programmable gap.
module piso_tx_ctrl #(
    parameter int WIDTH     = 8,
    parameter int GAP       = 2,
    parameter int MSB_FIRST = 0
) (
    input  logic          clk,
    input  logic          reset_p,
    piso_tx_ctrl_if.slave tx,
    output logic          sdo,
    output logic          sdo_en,
    output logic          busy,
    output logic          done,
    output logic [7:0]    frame_cnt
);
    localparam int BCW = $clog2(WIDTH);
    localparam int GCW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [BCW-1:0] BIT_LAST   = BCW'(WIDTH - 1);
    localparam logic [BCW-1:0] BIT_PENULT = BCW'(WIDTH - 2);
    localparam logic [GCW-1:0] GAP_LAST   = (GAP > 0) ? GCW'(GAP - 1) : '0;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [BCW-1:0]   bitcnt_q;
    logic [GCW-1:0]   gapcnt_q;
    logic             rdy_q;
    logic             done_q;
    logic [7:0]       frame_cnt_q;
    logic             accept;

    // rdy_q is the registered "may accept" flag; abort is the only input that gates it directly.
    assign tx.tx_ready = rdy_q && !tx.abort;
    assign accept      = tx.tx_valid && tx.tx_ready;

    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            gapcnt_q    <= '0;
            rdy_q       <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        shreg_q  <= tx.tx_data;
                        bitcnt_q <= '0;
                        state_q  <= ST_SHIFT;
                        rdy_q    <= 1'b0;
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (tx.abort) begin
                        state_q  <= ST_IDLE;
                        shreg_q  <= '0;
                        bitcnt_q <= '0;
                        rdy_q    <= 1'b1;
                    end else if (bitcnt_q == BIT_LAST) begin
                        done_q      <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        bitcnt_q    <= '0;
                        if (GAP > 0) begin
                            state_q  <= ST_GAP;
                            gapcnt_q <= '0;
                            shreg_q  <= shift_out(shreg_q);
                            rdy_q    <= 1'b0;
                        end else if (accept) begin
                            // Zero-gap chaining: the next word loads on the last-bit edge.
                            shreg_q <= tx.tx_data;
                            state_q <= ST_SHIFT;
                            rdy_q   <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            shreg_q <= shift_out(shreg_q);
                            rdy_q   <= 1'b1;
                        end
                    end else begin
                        shreg_q  <= shift_out(shreg_q);
                        bitcnt_q <= bitcnt_q + 1'b1;
                        rdy_q    <= (GAP == 0) && (bitcnt_q == BIT_PENULT);
                    end
                end
                ST_GAP: begin
                    if (tx.abort || (gapcnt_q == GAP_LAST)) begin
                        state_q  <= ST_IDLE;
                        shreg_q  <= '0;
                        gapcnt_q <= '0;
                        rdy_q    <= 1'b1;
                    end else begin
                        gapcnt_q <= gapcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign sdo_en    = (state_q == ST_SHIFT);
    assign sdo       = sdo_en && ((MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0]);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Bench for piso_tx_ctrl: three configurations (LSB/gap2, MSB/gap2, LSB/gap0) checked each
// cycle against a frame-timeline reference model.
module tb_piso_tx_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_p;
    logic [2:0] vld, abrt;
    logic [7:0] dat [3];
    logic [2:0] sdo_w, en_w, busy_w, done_w, rdy_w;
    logic [7:0] fc_w [3];

    piso_tx_ctrl_if #(.WIDTH(W)) if0 ();
    piso_tx_ctrl_if #(.WIDTH(W)) if1 ();
    piso_tx_ctrl_if #(.WIDTH(W)) if2 ();

    assign if0.tx_valid = vld[0];  assign if0.tx_data = dat[0];  assign if0.abort = abrt[0];
    assign if1.tx_valid = vld[1];  assign if1.tx_data = dat[1];  assign if1.abort = abrt[1];
    assign if2.tx_valid = vld[2];  assign if2.tx_data = dat[2];  assign if2.abort = abrt[2];
    assign rdy_w = {if2.tx_ready, if1.tx_ready, if0.tx_ready};

    piso_tx_ctrl #(.WIDTH(W), .GAP(2), .MSB_FIRST(0)) dut0 (
        .clk(clk), .reset_p(reset_p), .tx(if0), .sdo(sdo_w[0]), .sdo_en(en_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .frame_cnt(fc_w[0]));
    piso_tx_ctrl #(.WIDTH(W), .GAP(2), .MSB_FIRST(1)) dut1 (
        .clk(clk), .reset_p(reset_p), .tx(if1), .sdo(sdo_w[1]), .sdo_en(en_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .frame_cnt(fc_w[1]));
    piso_tx_ctrl #(.WIDTH(W), .GAP(0), .MSB_FIRST(0)) dut2 (
        .clk(clk), .reset_p(reset_p), .tx(if2), .sdo(sdo_w[2]), .sdo_en(en_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .frame_cnt(fc_w[2]));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: each config remembers the accept cycle and word of its last frame.
    bit         started [3];
    int         n0      [3];
    logic [7:0] word    [3];
    logic [7:0] fcm     [3];
    bit         donex   [3];
    bit         wrapx   [3];
    int         acc     [3];
    bit         rsthold;
    logic [7:0] cap     [3];
    int         capn    [3];
    int         run     [3];
    int         maxrun  [3];

    function automatic int gapof(input int c);
        return (c == 2) ? 0 : 2;
    endfunction

    function automatic bit msbof(input int c);
        return (c == 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_out();
        for (int c = 0; c < 3; c++) begin
            int k;
            bit inf, ing, es;
            k   = cyc - n0[c];
            inf = started[c] && (k < W);
            ing = started[c] && (k >= W) && (k < W + gapof(c));
            es  = 1'b0;
            if (inf) es = word[c][msbof(c) ? (W - 1 - k) : k];
            chk($sformatf("sdo%0d", c),    sdo_w[c],  es);
            chk($sformatf("sdo_en%0d", c), en_w[c],   inf);
            chk($sformatf("busy%0d", c),   busy_w[c], inf || ing);
            chk($sformatf("done%0d", c),   done_w[c], donex[c]);
            chk($sformatf("fcnt%0d", c),   fc_w[c],   fcm[c]);
            if (wrapx[c]) chk($sformatf("wrap%0d", c), fc_w[c], 0);
            if (en_w[c] === 1'b1) begin
                if (capn[c] < 8) cap[c][capn[c]] = sdo_w[c];
                capn[c]++;
                run[c]++;
                if (run[c] > maxrun[c]) maxrun[c] = run[c];
            end else begin
                run[c] = 0;
            end
        end
    endtask

    task automatic advance();
        for (int c = 0; c < 3; c++) begin
            int k;
            bit inf, ing, bsy, er, abe;
            k   = cyc - n0[c];
            inf = started[c] && (k < W);
            ing = started[c] && (k >= W) && (k < W + gapof(c));
            bsy = inf || ing;
            er  = (!bsy || (gapof(c) == 0 && inf && k == W - 1)) && !abrt[c] && !rsthold;
            chk($sformatf("tx_ready%0d", c), rdy_w[c], er);
            abe      = abrt[c] && bsy;
            donex[c] = inf && !abe && (k == W - 1);
            wrapx[c] = donex[c] && (fcm[c] == 8'hFF);
            if (donex[c]) fcm[c] = fcm[c] + 8'd1;
            if (abe) started[c] = 1'b0;
            if (er && vld[c]) begin
                started[c] = 1'b1;
                n0[c]      = cyc + 1;
                word[c]    = dat[c];
                acc[c]++;
            end
        end
        cyc++;
        rsthold = 1'b0;
    endtask

    task automatic step(input logic [2:0] v, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [2:0] a);
        @(negedge clk);
        check_out();
        vld = v; dat[0] = d0; dat[1] = d1; dat[2] = d2; abrt = a;
        #1;
        advance();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 8'h00, 8'h00, 8'h00, 3'b000);
    endtask

    task automatic send_all(input logic [7:0] d);
        step(3'b111, d, d, d, 3'b000);
    endtask

    task automatic reset_checks(input string tag);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("%s_sdo%0d", tag, c),  sdo_w[c],  0);
            chk($sformatf("%s_en%0d", tag, c),   en_w[c],   0);
            chk($sformatf("%s_busy%0d", tag, c), busy_w[c], 0);
            chk($sformatf("%s_done%0d", tag, c), done_w[c], 0);
            chk($sformatf("%s_fc%0d", tag, c),   fc_w[c],   0);
            chk($sformatf("%s_rdy%0d", tag, c),  rdy_w[c],  0);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            started[c] = 1'b0; fcm[c] = 8'h00; donex[c] = 1'b0; wrapx[c] = 1'b0;
        end
        rsthold = 1'b1;
    endtask

    task automatic clear_capture();
        for (int c = 0; c < 3; c++) begin
            cap[c] = 8'h00; capn[c] = 0; run[c] = 0; maxrun[c] = 0;
        end
    endtask

    initial begin
        logic [7:0] base;
        int         a0 [3];
        reset_p = 1'b0;
        vld = '0; abrt = '0;
        for (int c = 0; c < 3; c++) begin
            dat[c] = 8'h00; n0[c] = 0; word[c] = 8'h00; acc[c] = 0;
        end
        model_reset();
        clear_capture();

        #1 reset_p = 1'b1;
        #3 reset_checks("rst");
        @(posedge clk); #2 reset_p = 1'b0;
        idle(1);

        // Single 8'hBC frame on every config.
        clear_capture();
        send_all(8'hBC);
        idle(13);
        chk("lsb_seq", cap[0], 8'hBC);
        chk("msb_seq", cap[1], 8'h3D);
        chk("frame_cnt_1", fc_w[0], 8'd1);

        // Held valid, 8'hBC then 8'hA5.
        clear_capture();
        base = fcm[2];
        for (int c = 0; c < 3; c++) a0[c] = acc[c];
        for (int i = 0; i < 30; i++) begin
            logic [2:0] v;
            logic [7:0] d [3];
            for (int c = 0; c < 3; c++) begin
                v[c] = (acc[c] - a0[c]) < 2;
                d[c] = (acc[c] == a0[c]) ? 8'hBC : 8'hA5;
            end
            step(v, d[0], d[1], d[2], 3'b000);
        end
        idle(4);
        chk("b2b_run", maxrun[2], 16);
        chk("b2b_fc", fc_w[2], base + 8'd2);

        // Abort during bit 3, then a clean 8'hFF frame.
        idle(1);
        base = fcm[0];
        send_all(8'hBC);
        idle(3);
        step(3'b000, 8'h00, 8'h00, 8'h00, 3'b111);
        idle(3);
        chk("abort_fc", fc_w[0], base);
        send_all(8'hFF);
        idle(12);
        chk("ff_fc", fc_w[0], base + 8'd1);

        // Asynchronous reset between edges during bit 5.
        send_all(8'hAA);
        idle(5);
        @(posedge clk); #2 reset_p = 1'b1;
        #1 reset_checks("midrst");
        @(posedge clk); #2 reset_p = 1'b0;
        model_reset();
        idle(1);
        clear_capture();
        send_all(8'h01);
        idle(12);
        chk("rst01_lsb", cap[0], 8'h01);
        chk("rst01_msb", cap[1], 8'h80);
        chk("rst01_fc", fc_w[0], 8'd1);

        // Randomized traffic long enough for every frame counter to wrap.
        for (int i = 0; i < 4000; i++) begin
            logic [2:0] v, a;
            for (int c = 0; c < 3; c++) begin
                v[c] = ($urandom % 8) != 0;
                a[c] = ($urandom % 150) == 0;
            end
            step(v, 8'($urandom), 8'($urandom), 8'($urandom), a);
        end
        idle(14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
